// File: rtl/sar_search8_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sar_search8_pkg
// Description : Shared definitions for the successive-approximation search
//               block: default operand width and FSM state encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package sar_search8_pkg;

    // Default operand width of the search.
    localparam int c_SAR_W = 8;

    // FSM state encodings (2-bit, explicit width).
    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_SEARCH = 2'd1;
    localparam logic [1:0] c_ST_DONE   = 2'd2;

endpackage : sar_search8_pkg
`default_nettype wire

// File: rtl/sar_search8.sv
`default_nettype none
// ============================================================================
// Module      : sar_search8
// Description : Successive-approximation search. Recovers an unknown value x
//               MSB-first by proposing trial operands to an external ">="
//               comparator (x >= trial) and keeping or clearing each bit
//               according to the returned geq result.
// Ports       : clk         - sole clock, rising edge
//               reset       - synchronous active-high reset
//               start       - begin a search (honoured only in IDLE)
//               abort       - cancel an in-progress search
//               trial       - candidate operand for the external comparator
//               trial_valid - trial is stable and awaits a comparison
//               geq         - comparator result for the current trial
//               geq_valid   - comparator result strobe
//               busy        - search in progress
//               done        - one-cycle completion pulse
//               result      - recovered value, held until next completion
// Revision    : 1.0 - initial release
// ============================================================================
module sar_search8
    import sar_search8_pkg::*;
#(
    parameter int W = c_SAR_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         abort,
    output logic [W-1:0] trial,
    output logic         trial_valid,
    input  logic         geq,
    input  logic         geq_valid,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result
);

    localparam int             c_IW      = (W > 1) ? $clog2(W) : 1;
    localparam logic [c_IW-1:0] c_TOP_IDX = c_IW'(W - 1);
    localparam logic [W-1:0]   c_MSB_ONE = {1'b1, {(W-1){1'b0}}};

    logic [1:0]      r_state;
    logic [W-1:0]    r_trial;
    logic [c_IW-1:0] r_idx;
    logic [W-1:0]    r_result;

    logic [1:0]      w_state_nxt;
    logic [W-1:0]    w_trial_nxt;
    logic [c_IW-1:0] w_idx_nxt;
    logic [W-1:0]    w_result_nxt;
    logic [W-1:0]    w_trial_upd;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= c_ST_IDLE;
            r_trial  <= '0;
            r_idx    <= '0;
            r_result <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_trial  <= w_trial_nxt;
            r_idx    <= w_idx_nxt;
            r_result <= w_result_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath update
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_trial_nxt  = r_trial;
        w_idx_nxt    = r_idx;
        w_result_nxt = r_result;

        // Trial after resolving the current bit: keep it on geq=1, clear it
        // on geq=0, and propose the next lower bit when one remains.
        w_trial_upd        = r_trial;
        w_trial_upd[r_idx] = geq;
        if (r_idx != '0) begin
            w_trial_upd[r_idx - 1'b1] = 1'b1;
        end

        case (r_state)
            c_ST_IDLE: begin
                if (start) begin
                    w_state_nxt = c_ST_SEARCH;
                    w_trial_nxt = c_MSB_ONE;
                    w_idx_nxt   = c_TOP_IDX;
                end
            end
            c_ST_SEARCH: begin
                // abort wins over a same-cycle comparator result
                if (abort) begin
                    w_state_nxt = c_ST_IDLE;
                    w_trial_nxt = '0;
                    w_idx_nxt   = '0;
                end else if (geq_valid) begin
                    if (r_idx == '0) begin
                        w_state_nxt  = c_ST_DONE;
                        w_result_nxt = w_trial_upd;
                        w_trial_nxt  = '0;
                    end else begin
                        w_trial_nxt = w_trial_upd;
                        w_idx_nxt   = r_idx - 1'b1;
                    end
                end
            end
            c_ST_DONE: begin
                w_state_nxt = c_ST_IDLE;
                w_trial_nxt = '0;
                w_idx_nxt   = '0;
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
                w_trial_nxt = '0;
                w_idx_nxt   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        trial       = r_trial;
        result      = r_result;
        busy        = (r_state == c_ST_SEARCH);
        trial_valid = (r_state == c_ST_SEARCH);
        done        = (r_state == c_ST_DONE);
    end

endmodule : sar_search8
`default_nettype wire

// File: tb/tb_sar_search8.sv
`default_nettype none
// ============================================================================
// Module      : tb_sar_search8
// Description : Self-checking bench for sar_search8 with an external ">="
//               comparator model, directed scenarios and randomized traffic
//               checked cycle by cycle against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sar_search8;

    logic       clk = 1'b0;
    logic       reset, start, abort, geq, geq_valid;
    logic [7:0] trial, result;
    logic       trial_valid, busy, done;

    logic [7:0] x;
    int         cmp_mode;   // 0: tied-high valid, 1: 2-cycle delayed, 2: random valid
    int         n_checks = 0;
    int         n_fail   = 0;

    always #5 clk = ~clk;

    sar_search8 #(.W(8)) u_dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .abort       (abort),
        .trial       (trial),
        .trial_valid (trial_valid),
        .geq         (geq),
        .geq_valid   (geq_valid),
        .busy        (busy),
        .done        (done),
        .result      (result)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // External comparator, updated on the falling edge
    // ------------------------------------------------------------------
    initial begin : p_cmp
        logic [7:0] last_trial;
        int         stable;
        geq = 1'b0; geq_valid = 1'b0; last_trial = 8'h00; stable = 0;
        forever begin
            @(negedge clk);
            if (trial !== last_trial) begin
                stable     = 0;
                last_trial = trial;
            end else if (stable < 15) begin
                stable++;
            end
            case (cmp_mode)
                0: begin
                    geq_valid = 1'b1;
                    geq       = (x >= trial);
                end
                1: begin
                    geq_valid = trial_valid && (stable == 2);
                    geq       = geq_valid ? (x >= trial) : 1'($urandom_range(1));
                end
                default: begin
                    geq_valid = 1'($urandom_range(1));
                    geq       = geq_valid ? (x >= trial) : 1'($urandom_range(1));
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Behavioural model: k bits resolved so far, acc holds the resolved
    // bits. Expected trial = resolved bits plus the next bit to test.
    // ------------------------------------------------------------------
    int         m_phase = 0;   // 0 idle, 1 searching, 2 completion cycle
    int         m_k     = 0;
    logic [7:0] m_acc   = 8'h00;
    logic [7:0] m_res   = 8'h00;
    int         n_rand_done = 0;

    always begin : p_model
        logic s_rst, s_start, s_abort, s_gv, s_g;
        logic [7:0] e_trial;
        @(posedge clk);
        s_rst = reset; s_start = start; s_abort = abort; s_gv = geq_valid; s_g = geq;
        if (s_rst) begin
            m_phase = 0;
            m_res   = 8'h00;
        end else begin
            case (m_phase)
                0: if (s_start) begin
                    m_phase = 1; m_k = 0; m_acc = 8'h00;
                end
                1: if (s_abort) begin
                    m_phase = 0;
                end else if (s_gv) begin
                    if (s_g) m_acc = m_acc | (8'h80 >> m_k);
                    m_k++;
                    if (m_k == 8) begin
                        m_res   = m_acc;
                        m_phase = 2;
                    end
                end
                default: m_phase = 0;
            endcase
        end
        e_trial = (m_phase == 1) ? (m_acc | (8'h80 >> m_k)) : 8'h00;
        #1;
        check("cmp_trial",       trial,       e_trial);
        check("cmp_trial_valid", trial_valid, m_phase == 1);
        check("cmp_busy",        busy,        m_phase == 1);
        check("cmp_done",        done,        m_phase == 2);
        check("cmp_result",      result,      m_res);
        if (done === 1'b1 && cmp_mode == 2) n_rand_done++;
    end

    // Pulse start with value xv and count cycles until done (first SEARCH
    // cycle is cycle 1). Returns at the falling edge inside the done cycle.
    task automatic run_one(input logic [7:0] xv, output int dcyc);
        @(negedge clk);
        x = xv; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dcyc  = 1;
        while (done !== 1'b1 && dcyc < 200) begin
            @(negedge clk);
            dcyc++;
        end
    endtask

    initial begin : p_watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Directed and randomized stimulus
    // ------------------------------------------------------------------
    initial begin : p_stim
        logic [7:0] seq [8];
        logic [7:0] exp_seq [8];
        int         dcyc;
        logic       seen_done;

        exp_seq = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};
        reset = 1'b1; start = 1'b0; abort = 1'b0; x = 8'h00; cmp_mode = 0;
        repeat (3) @(negedge clk);
        check("rst_trial", trial, 8'h00);
        check("rst_busy",  busy,  1'b0);
        check("rst_done",  done,  1'b0);
        check("rst_tv",    trial_valid, 1'b0);
        check("rst_result", result, 8'h00);
        reset = 1'b0;

        // x = A5, tied-high comparator: trial sequence and latency
        @(negedge clk);
        x = 8'hA5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 8; c++) begin
            seq[c] = trial;
            check("a5_busy", busy, 1'b1);
            @(negedge clk);
        end
        for (int c = 0; c < 8; c++) check("a5_trial_seq", seq[c], exp_seq[c]);
        check("a5_done_cycle9", done, 1'b1);
        check("a5_result", result, 8'hA5);
        @(negedge clk);
        check("a5_done_width", done, 1'b0);

        // boundaries 00 and FF
        run_one(8'h00, dcyc);
        check("x00_latency", dcyc, 9);
        check("x00_result", result, 8'h00);
        @(negedge clk);
        check("x00_done_width", done, 1'b0);
        run_one(8'hFF, dcyc);
        check("xFF_latency", dcyc, 9);
        check("xFF_result", result, 8'hFF);
        @(negedge clk);
        check("xFF_done_width", done, 1'b0);

        // registered comparator: 3 cycles per bit
        cmp_mode = 1;
        run_one(8'h3C, dcyc);
        check("x3C_latency", dcyc, 25);
        check("x3C_result", result, 8'h3C);
        @(negedge clk);
        cmp_mode = 0;

        // start held high: one search, restart only after IDLE
        @(negedge clk);
        x = 8'hA5; start = 1'b1;
        @(negedge clk);
        repeat (8) @(negedge clk);
        check("hold_done", done, 1'b1);
        @(negedge clk);
        check("hold_idle_busy", busy, 1'b0);
        check("hold_idle_done", done, 1'b0);
        @(negedge clk);
        check("hold_restart_busy", busy, 1'b1);
        check("hold_restart_trial", trial, 8'h80);
        start = 1'b0;
        repeat (12) @(negedge clk);
        check("hold_result", result, 8'hA5);

        // abort at 4th SEARCH cycle
        x = 8'h33; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", busy, 1'b0);
        check("abort_trial", trial, 8'h00);
        check("abort_result", result, 8'hA5);
        seen_done = 1'b0;
        for (int c = 0; c < 12; c++) begin
            if (done === 1'b1) seen_done = 1'b1;
            @(negedge clk);
        end
        check("abort_no_done", seen_done, 1'b0);

        // reset at 5th SEARCH cycle
        x = 8'h77; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_busy", busy, 1'b0);
        check("midrst_trial", trial, 8'h00);
        check("midrst_result", result, 8'h00);
        run_one(8'h5A, dcyc);
        check("x5A_latency", dcyc, 9);
        check("x5A_result", result, 8'h5A);
        @(negedge clk);

        // randomized traffic, checked by the model every cycle
        cmp_mode = 2;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            start = ($urandom_range(3) == 0);
            abort = ($urandom_range(23) == 0);
            reset = ($urandom_range(299) == 0);
            if (busy !== 1'b1) x = 8'($urandom);
        end
        start = 1'b0; abort = 1'b0; reset = 1'b0;
        repeat (60) @(negedge clk);
        check("rand_done_seen", n_rand_done > 0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_sar_search8
`default_nettype wire

// File: doc/sar_search8.md
SAR_SEARCH8 -- requirements
Module: sar_search8

Interface
REQ-001 Parameter: W, 8, operand width in bits; the module SHALL be verified at W=8 only.
REQ-002 clk  input  1  sole clock; all state SHALL update on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 start  input  1  request a new search; accepted only in IDLE.
REQ-005 abort  input  1  cancel an in-progress search.
REQ-006 trial  output  W  candidate operand driven to the external ">=" comparator (unknown x >= trial).
REQ-007 trial_valid  output  1  high while trial is stable and awaiting a comparison result.
REQ-008 geq  input  1  comparator result for the current trial; meaningful only when geq_valid=1.
REQ-009 geq_valid  input  1  comparator result-valid strobe; tie high for a combinational comparator.
REQ-010 busy  output  1  high in SEARCH.
REQ-011 done  output  1  single-cycle completion pulse.
REQ-012 result  output  W  recovered value of x; held until the next completion.

Function
REQ-013 The block SHALL implement a successive-approximation search: the inverse of the ">=" comparator, recovering x MSB-first from geq feedback.
REQ-014 States SHALL be IDLE, SEARCH and DONE.
REQ-015 IDLE: trial=0, trial_valid=0, busy=0, done=0; start=1 -> SEARCH with trial={1,0...0}, bit index=W-1.
REQ-016 SEARCH: trial_valid=1, busy=1; on a cycle with geq_valid=1, bit[index] of trial SHALL be kept if geq=1, cleared if geq=0, and bit[index-1] SHALL be set in the same update.
REQ-017 SEARCH cycles with geq_valid=0 SHALL hold trial and index unchanged.
REQ-018 On the accepted geq for index 0: result SHALL load the final trial value -> DONE.
REQ-019 DONE SHALL last exactly one cycle with done=1, busy=0, trial_valid=0 -> IDLE.
REQ-020 start SHALL be ignored in SEARCH and DONE; no queuing.
REQ-021 abort=1 in SEARCH SHALL force IDLE next cycle; result unchanged; no done pulse; abort has priority over geq_valid in the same cycle.
REQ-022 abort in IDLE or DONE SHALL have no effect.
REQ-023 Latency: with geq_valid tied high, done SHALL assert W+1 cycles after the start-accept edge (cycle 9 for W=8).
REQ-024 The index counter SHALL be ceil(log2 W) bits and SHALL NOT wrap; the transition out of SEARCH is taken at index 0.

Reset
REQ-025 reset=1 SHALL, from any state including mid-search, force IDLE with trial=0, trial_valid=0, busy=0, done=0 and result=0 on the next edge.
REQ-026 reset SHALL take priority over start, abort and geq_valid.

Structure
REQ-027 State encodings (IDLE, SEARCH, DONE) and the default W SHALL live in the shared ALU definitions package or header, not in the module.
REQ-028 The block SHALL be a single module containing the FSM, the trial register and the index counter; no sub-module SHALL be used.
REQ-029 The block SHALL contain no comparator; the ">=" comparison SHALL be external.

Verification
REQ-030 Test: x=8'hA5, geq_valid tied 1, pulse start -> trial sequence 80,C0,A0,B0,A8,A4,A6,A5; result=A5; done pulses at cycle 9.
REQ-031 Test: x=8'h00, then x=8'hFF -> result=00, then result=FF; each done pulse is one cycle wide.
REQ-032 Test: registered comparator with geq_valid arriving 2 cycles after each trial change, x=8'h3C -> result=3C; trial is stable while awaiting geq_valid; done asserts 24 cycles after start-accept, +1.
REQ-033 Test: start held high throughout a search -> exactly one search runs; a second search starts only after IDLE is re-entered.
REQ-034 Test: abort at the 4th SEARCH cycle -> IDLE next cycle, no done, result keeps its previous value (A5).
REQ-035 Test: reset asserted at the 5th SEARCH cycle -> next edge gives busy=0, trial=0, result=0; a subsequent start with x=8'h5A -> result=5A.
